iseq_arbiter_router: RTL and testbench

// Multi-source instruction receiver: collects 32-bit SoftMC instruction sequences from
// NUM_SRC requesters (app, maintenance, refresh, ...), grants one whole sequence at a time
// (round-robin), and stripes its instructions across NUM_FIFO dispatcher instruction FIFOs.

---
 rtl/iseq_arbiter_router.sv | 194 +++++++++++++++++++
 tb/tb_iseq_arbiter_router.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iseq_arbiter_router.sv
// iseq_arbiter_router
// Collects SoftMC instruction sequences from NUM_SRC requesters, grants one whole
// sequence at a time in round-robin order and stripes its words across NUM_FIFO
// dispatcher instruction FIFOs. process_iseq pulses once the END_ISEQ word of the
// granted sequence has been handled.
// Optional stall timeout: define ISEQ_TIMEOUT_EN to abort a sequence whose source
// stops delivering words for TIMEOUT_CYC cycles.
//
// state     | meaning
// ST_IDLE   | no sequence owned; a new source may be granted
// ST_LOCKED | granted source owns the FIFOs until its END_ISEQ word

`ifndef END_ISEQ
`define END_ISEQ 4'b0000
`endif

module iseq_arbiter_router #(
    parameter int                 NUM_SRC     = 2,
    parameter int                 NUM_FIFO    = 2,
    parameter int                 INSTR_W     = 32,
    parameter logic [NUM_SRC-1:0] DROP_END    = 2'b10,
    parameter int                 LEN_W       = 16,
    parameter int                 TIMEOUT_CYC = 1024,
    localparam int                SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int                SEL_W       = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dispatcher_ready,
    input  logic [NUM_SRC-1:0]         src_en,
    output logic [NUM_SRC-1:0]         src_ack,
    input  logic [NUM_SRC*INSTR_W-1:0] src_instr,
    input  logic [NUM_FIFO-1:0]        fifo_full,
    output logic [NUM_FIFO-1:0]        fifo_en,
    output logic [INSTR_W-1:0]         fifo_data,
    output logic                       process_iseq,
    output logic [SRC_W-1:0]           iseq_src,
    output logic [LEN_W-1:0]           iseq_len,
    output logic                       iseq_abort
);

    if (NUM_SRC < 1 || NUM_SRC > 8 || NUM_FIFO < 1 || NUM_FIFO > 4 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("iseq_arbiter_router: parameter out of range");
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SRC_W-1:0]   rr_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SRC_W-1:0]   cand;
    logic [SRC_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic [SRC_W-1:0]   cur_src;
    logic [INSTR_W-1:0] cur_instr;
    logic               is_end;
    logic               do_write;
    logic               lk_accept;
    logic               grant;
    logic               accept;
    logic               stall_tc;
    logic [NUM_SRC-1:0] ack;

    // round-robin search: first requester after the most recently granted source
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        cand      = rr_q;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = SRC_W'((int'(rr_q) + i) % NUM_SRC);
            if (!gnt_found && src_en[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // while idle the candidate is the round-robin winner, otherwise the owner
    assign cur_src   = (state_q == ST_IDLE) ? gnt_idx : iseq_src;
    assign cur_instr = src_instr[int'(cur_src)*INSTR_W +: INSTR_W];
    assign is_end    = (cur_instr[INSTR_W-1 -: 4] == `END_ISEQ);
    assign do_write  = ~(is_end & DROP_END[cur_src]);
    assign lk_accept = src_en[iseq_src] & ~fifo_full[sel_q];

    // next-state and handshake decode
    always_comb begin
        state_d = state_q;
        ack     = '0;
        grant   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // no grant while the previous completion pulse is still visible
                if (dispatcher_ready && !process_iseq && gnt_found) begin
                    grant        = 1'b1;
                    accept       = 1'b1;
                    ack[gnt_idx] = 1'b1;
                    if (!is_end) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                ack[iseq_src] = ~fifo_full[sel_q];
                accept        = lk_accept;
                if ((lk_accept && is_end) || stall_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // acks are forced low while reset is held so sources never see a stale handshake
    assign src_ack = ack & {NUM_SRC{rst_n}};

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // write pipeline, stripe pointer, round-robin pointer and sequence bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= SRC_W'(NUM_SRC - 1);
            sel_q        <= '0;
            iseq_src     <= '0;
            iseq_len     <= '0;
            fifo_en      <= '0;
            fifo_data    <= '0;
            process_iseq <= 1'b0;
        end else begin
            fifo_en      <= '0;
            process_iseq <= accept & is_end;
            if (grant) begin
                rr_q     <= gnt_idx;
                iseq_src <= gnt_idx;
                iseq_len <= '0;
            end
            if (accept && do_write) begin
                fifo_en   <= NUM_FIFO'(1) << sel_q;
                fifo_data <= cur_instr;
                sel_q     <= (sel_q == SEL_W'(NUM_FIFO - 1)) ? '0 : sel_q + 1'b1;
                if (grant) begin
                    iseq_len <= LEN_W'(1);
                end else if (!(&iseq_len)) begin
                    iseq_len <= iseq_len + 1'b1;
                end
            end
            // every sequence, completed or aborted, restarts striping at FIFO 0
            if ((accept && is_end) || stall_tc) begin
                sel_q <= '0;
            end
        end
    end

`ifdef ISEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] stall_tmr_q;
    logic             abort_q;

    assign stall_tc = (state_q == ST_LOCKED) && !lk_accept && (stall_tmr_q == TMR_W'(1));

    // stall down-counter: reloads on every accepted word, expires at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_tmr_q <= TMR_W'(TIMEOUT_CYC);
            abort_q     <= 1'b0;
        end else begin
            abort_q <= stall_tc;
            if (accept) begin
                stall_tmr_q <= TMR_W'(TIMEOUT_CYC);
            end else if (state_q == ST_LOCKED) begin
                stall_tmr_q <= stall_tmr_q - 1'b1;
            end
        end
    end

    assign iseq_abort = abort_q;
`else
    assign stall_tc   = 1'b0;
    assign iseq_abort = 1'b0;
`endif

endmodule

// File: tb/tb_iseq_arbiter_router.sv
// Bench for iseq_arbiter_router: sources are word queues, the reference model works
// on sequences (owner, words written so far, last granted source) and predicts the
// handshake, the FIFO write stream and the completion/abort pulses.

`ifndef END_ISEQ
`define END_ISEQ 4'b0000
`endif

module tb_iseq_arbiter_router;

    localparam int         NSRC   = 2;
    localparam int         NFIFO  = 2;
    localparam logic [1:0] DROP   = 2'b10;
    localparam int         TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dispatcher_ready;
    logic [1:0]  src_en;
    logic [1:0]  src_ack;
    logic [63:0] src_instr;
    logic [1:0]  fifo_full;
    logic [1:0]  fifo_en;
    logic [31:0] fifo_data;
    logic        process_iseq;
    logic [0:0]  iseq_src;
    logic [15:0] iseq_len;
    logic        iseq_abort;

    always #5 clk = ~clk;

    iseq_arbiter_router #(
        .NUM_SRC    (NSRC),
        .NUM_FIFO   (NFIFO),
        .INSTR_W    (32),
        .DROP_END   (DROP),
        .LEN_W      (16),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dispatcher_ready(dispatcher_ready),
        .src_en          (src_en),
        .src_ack         (src_ack),
        .src_instr       (src_instr),
        .fifo_full       (fifo_full),
        .fifo_en         (fifo_en),
        .fifo_data       (fifo_data),
        .process_iseq    (process_iseq),
        .iseq_src        (iseq_src),
        .iseq_len        (iseq_len),
        .iseq_abort      (iseq_abort)
    );

    int n_chk;
    int n_err;

    logic [31:0] src_q [2][$];
    int          en_pct, full_pct, rdy_pct;
    logic [1:0]  src_hold;
    logic [1:0]  force_full;

    // sequence-level reference state
    int          m_locked, m_g, m_last, m_wcnt, m_end_prev, m_stall;
    logic [1:0]  exp_fen;
    logic [31:0] exp_fdata;
    logic        exp_proc, exp_abort;
    int          exp_len, exp_src;

    int          n_writes, n_proc, n_abort, n_acks;
    logic [1:0]  fen_log [$];
    int          src_log [$];

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if (w[31:28] == `END_ISEQ) w[31:28] = ~w[31:28];
        return w;
    endfunction

    task automatic push_seq(input int s, input int n);
        logic [31:0] w;
        for (int k = 0; k < n; k++) src_q[s].push_back(rand_instr());
        w = $urandom;
        w[31:28] = `END_ISEQ;
        src_q[s].push_back(w);
    endtask

    // drop the unsent remainder of the sequence a source is in the middle of
    task automatic flush_cur(input int s);
        logic [31:0] w;
        while (src_q[s].size() > 0) begin
            w = src_q[s].pop_front();
            if (w[31:28] == `END_ISEQ) break;
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_g = 0; m_last = NSRC - 1; m_wcnt = 0; m_end_prev = 0; m_stall = 0;
        exp_fen = '0; exp_fdata = '0; exp_proc = 1'b0; exp_abort = 1'b0; exp_len = 0; exp_src = 0;
    endtask

    task automatic step();
        logic [1:0]  exp_ack;
        int          win;
        logic [31:0] w;
        logic        is_end, wr;
        for (int s = 0; s < NSRC; s++) begin
            if (src_q[s].size() > 0 && !src_hold[s] && $urandom_range(99) < en_pct) begin
                src_en[s] = 1'b1;
                src_instr[s*32 +: 32] = src_q[s][0];
            end else begin
                src_en[s] = 1'b0;
                src_instr[s*32 +: 32] = $urandom;
            end
        end
        for (int f = 0; f < NFIFO; f++) fifo_full[f] = force_full[f] | ($urandom_range(99) < full_pct);
        dispatcher_ready = ($urandom_range(99) < rdy_pct);
        #1;
        exp_ack = '0;
        win = -1;
        if (m_locked != 0) begin
            exp_ack[m_g] = ~fifo_full[m_wcnt % NFIFO];
        end else if (dispatcher_ready && m_end_prev == 0) begin
            for (int k = 1; k <= NSRC; k++) begin
                if (win < 0 && src_en[(m_last + k) % NSRC]) win = (m_last + k) % NSRC;
            end
            if (win >= 0) exp_ack[win] = 1'b1;
        end
        chk_eq("src_ack", src_ack, exp_ack);
        if (src_ack != 0) n_acks++;

        exp_fen = '0; exp_proc = 1'b0; exp_abort = 1'b0; m_end_prev = 0;
        win = -1;
        for (int s = 0; s < NSRC; s++) if (exp_ack[s] && src_en[s]) win = s;
        if (win >= 0) begin
            w = src_q[win].pop_front();
            if (m_locked == 0) begin
                m_locked = 1; m_g = win; m_last = win; m_wcnt = 0; exp_len = 0; exp_src = win;
            end
            m_stall = 0;
            is_end = (w[31:28] == `END_ISEQ);
            wr = !(is_end && DROP[win]);
            if (wr) begin
                exp_fen = 2'(1 << (m_wcnt % NFIFO));
                exp_fdata = w;
                m_wcnt++;
                if (exp_len < 65535) exp_len++;
            end
            if (is_end) begin
                m_locked = 0; exp_proc = 1'b1; m_end_prev = 1;
            end
        end else if (m_locked != 0) begin
`ifdef ISEQ_TIMEOUT_EN
            m_stall++;
            if (m_stall == TO_CYC) begin
                exp_abort = 1'b1; m_locked = 0; m_stall = 0;
                flush_cur(m_g);
            end
`endif
        end

        @(posedge clk);
        #1;
        chk_eq("fifo_en", fifo_en, exp_fen);
        if (exp_fen != 0) chk_eq("fifo_data", fifo_data, exp_fdata);
        chk_eq("process_iseq", process_iseq, exp_proc);
        chk_eq("iseq_abort", iseq_abort, exp_abort);
        chk_eq("iseq_len", iseq_len, exp_len);
        chk_eq("iseq_src", iseq_src, exp_src);
        if (fifo_en != 0) begin
            n_writes++;
            fen_log.push_back(fifo_en);
        end
        if (process_iseq) begin
            n_proc++;
            src_log.push_back(int'(iseq_src));
        end
        if (iseq_abort) n_abort++;
    endtask

    task automatic do_reset();
        if (m_locked != 0) flush_cur(m_g);
        rst_n = 1'b0;
        #1;
        chk_eq("rst_src_ack", src_ack, 0);
        chk_eq("rst_fifo_en", fifo_en, 0);
        chk_eq("rst_fifo_data", fifo_data, 0);
        chk_eq("rst_process", process_iseq, 0);
        chk_eq("rst_abort", iseq_abort, 0);
        chk_eq("rst_len", iseq_len, 0);
        chk_eq("rst_src", iseq_src, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((src_q[0].size() + src_q[1].size() > 0 || m_locked != 0) && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        chk_eq("drain_left", src_q[0].size() + src_q[1].size(), 0);
    endtask

    initial begin
        int g, acks0, stall_len, exp_aborts;
        n_chk = 0; n_err = 0;
        en_pct = 100; full_pct = 0; rdy_pct = 100;
        src_hold = '0; force_full = '0;
        n_writes = 0; n_proc = 0; n_abort = 0; n_acks = 0;
        rst_n = 1'b1; dispatcher_ready = 1'b1; src_en = 2'b11; src_instr = '0; fifo_full = '0;
        model_reset();
        #2;
        do_reset();

        // single sequence from src0 striped 01,10,01,10
        fen_log.delete(); n_proc = 0;
        push_seq(0, 3);
        drain(50);
        chk_eq("t1_nwr", fen_log.size(), 4);
        for (int k = 0; k < 4; k++) chk_eq("t1_fen", fen_log[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        chk_eq("t1_len", iseq_len, 4);
        chk_eq("t1_proc", n_proc, 1);

        // simultaneous requests: round-robin order 0,1,0
        do_reset();
        src_log.delete();
        push_seq(0, 2); push_seq(0, 1); push_seq(1, 2);
        drain(100);
        chk_eq("t2_ngrant", src_log.size(), 3);
        chk_eq("t2_order0", src_log[0], 0);
        chk_eq("t2_order1", src_log[1], 1);
        chk_eq("t2_order2", src_log[2], 0);

        // src1 drops its END word
        n_writes = 0; n_proc = 0;
        push_seq(1, 2);
        drain(50);
        chk_eq("t3_writes", n_writes, 2);
        chk_eq("t3_proc", n_proc, 1);
        chk_eq("t3_len", iseq_len, 2);

        // FIFO1 full for 5 cycles while word 2 waits
        fen_log.delete();
        push_seq(0, 5);
        g = 0;
        while (!(m_locked != 0 && m_wcnt == 1) && g < 50) begin
            step();
            g++;
        end
        force_full[1] = 1'b1;
        acks0 = n_acks;
        repeat (5) step();
        chk_eq("t4_stall_acks", n_acks - acks0, 0);
        force_full[1] = 1'b0;
        drain(50);
        chk_eq("t4_nwr", fen_log.size(), 6);
        for (int k = 0; k < 6; k++) chk_eq("t4_fen", fen_log[k], (k % 2 == 0) ? 2'b01 : 2'b10);

        // reset mid-sequence, next grant restarts at FIFO 0
        push_seq(0, 5);
        repeat (3) step();
        do_reset();
        n_proc = 0; fen_log.delete();
        push_seq(1, 1);
        drain(50);
        chk_eq("t5_first_fen", fen_log[0], 2'b01);
        chk_eq("t5_proc", n_proc, 1);

        // stalled source: abort only when the timeout is built in
`ifdef ISEQ_TIMEOUT_EN
        stall_len = TO_CYC + 4;
        exp_aborts = 1;
`else
        stall_len = 1000;
        exp_aborts = 0;
`endif
        n_abort = 0;
        push_seq(0, 1);
        g = 0;
        while (m_locked == 0 && g < 20) begin
            step();
            g++;
        end
        src_hold[0] = 1'b1;
        repeat (stall_len) step();
        chk_eq("t6_aborts", n_abort, exp_aborts);
        src_hold[0] = 1'b0;
        drain(50);

        // randomized traffic with backpressure and dispatcher_ready toggling
        do_reset();
        en_pct = 70; full_pct = 25; rdy_pct = 70;
        for (int k = 0; k < 30; k++) push_seq($urandom_range(1), $urandom_range(6));
        drain(4000);
        for (int k = 0; k < 30; k++) push_seq($urandom_range(1), $urandom_range(3));
        drain(4000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
